// File: rtl/mcu_sequencer_if.sv
// Load-port and issue-port signals for mcu_sequencer.
// master = program loader / execution unit side, slave = sequencer side.
interface mcu_sequencer_if #(
  parameter int unsigned OP_SZ   = 32,
  parameter int unsigned MEM_SZ  = 10,
  parameter int unsigned PROG_SZ = 6
);
  localparam int unsigned INSTR_W = 4 + 2 * MEM_SZ + OP_SZ;

  logic               ld_valid;
  logic               ld_ready;
  logic [PROG_SZ-1:0] ld_addr;
  logic [INSTR_W-1:0] ld_data;

  logic [3:0]         op;
  logic [MEM_SZ-1:0]  op0;
  logic [OP_SZ-1:0]   op1;
  logic [MEM_SZ-1:0]  op2;
  logic               op_err;

  modport master (
    output ld_valid, ld_addr, ld_data, op_err,
    input  ld_ready, op, op0, op1, op2
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, op_err,
    output ld_ready, op, op0, op1, op2
  );
endinterface

// File: rtl/mcu_sequencer.sv
// Program-memory instruction sequencer: loads words, then issues one per RUN cycle.
// Optional single-step gating is enabled with the MCU_SEQUENCER_STEP_EN macro.
module mcu_sequencer #(
  parameter int unsigned OP_SZ   = 32,
  parameter int unsigned MEM_SZ  = 10,
  parameter int unsigned PROG_SZ = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
`ifdef MCU_SEQUENCER_STEP_EN
  input  logic               step,
`endif
  mcu_sequencer_if.slave     bus,
  output logic [PROG_SZ-1:0] pc,
  output logic [15:0]        issue_cnt,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned INSTR_W = 4 + 2 * MEM_SZ + OP_SZ;
  localparam logic [3:0] OpNop = 4'd7;
  localparam logic [3:0] OpEnd = 4'd15;
  localparam logic [3:0] OpMaxLegal = 4'd8;
  localparam logic [PROG_SZ-1:0] PcLast = '1;
  localparam logic [INSTR_W-1:0] NopWord = {OpNop, {(INSTR_W - 4){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

  state_e             state_q, state_d;
  logic [PROG_SZ-1:0] pc_q, pc_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [INSTR_W-1:0] out_q, out_d;
  logic [INSTR_W-1:0] prog_q [2**PROG_SZ];
  logic [INSTR_W-1:0] word;
  logic [3:0]         word_op;
  logic               step_en;
  logic               ld_fire;

`ifdef MCU_SEQUENCER_STEP_EN
  assign step_en = step;
`else
  assign step_en = 1'b1;
`endif

  assign word    = prog_q[pc_q];
  assign word_op = word[INSTR_W-4 +: 4];
  assign ld_fire = bus.ld_valid && bus.ld_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    out_d   = NopWord;
    case (state_q)
      StRun: begin
        // Abort sources outrank decode of the fetched word.
        if (halt_req) begin
          state_d = StIdle;
        end else if (bus.op_err) begin
          state_d = StErr;
        end else if (step_en) begin
          if (word_op == OpEnd) begin
            state_d = StDone;
          end else if (word_op > OpMaxLegal) begin
            state_d = StErr;
          end else begin
            out_d = word;
            cnt_d = cnt_q + 16'd1;
            // Last address finishes the program instead of wrapping pc.
            if (pc_q == PcLast) begin
              state_d = StDone;
            end else begin
              pc_d = pc_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      out_q   <= NopWord;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Program memory is deliberately outside reset so a reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      prog_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  assign bus.ld_ready = (state_q != StRun);
  assign bus.op       = out_q[INSTR_W-4 +: 4];
  assign bus.op0      = out_q[MEM_SZ+OP_SZ +: MEM_SZ];
  assign bus.op1      = out_q[MEM_SZ +: OP_SZ];
  assign bus.op2      = out_q[0 +: MEM_SZ];

  assign pc        = pc_q;
  assign issue_cnt = cnt_q;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign err       = (state_q == StErr);

endmodule

// File: tb/tb_mcu_sequencer.sv
// Scoreboard bench for mcu_sequencer: expected issue words and edges are queued
// at stimulus time and compared by a negedge monitor.
module tb_mcu_sequencer;
  localparam int unsigned INSTR_W = 56;
  localparam logic [INSTR_W-1:0] NopWord = {4'd7, 52'd0};

  typedef struct {
    logic [INSTR_W-1:0] w;
    int                 cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt_req;
`ifdef MCU_SEQUENCER_STEP_EN
  logic        step;
`endif
  logic [5:0]  pc;
  logic [15:0] issue_cnt;
  logic        busy, done, err;

  mcu_sequencer_if #(.OP_SZ(32), .MEM_SZ(10), .PROG_SZ(6)) bus ();

  mcu_sequencer #(.OP_SZ(32), .MEM_SZ(10), .PROG_SZ(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .halt_req  (halt_req),
`ifdef MCU_SEQUENCER_STEP_EN
    .step      (step),
`endif
    .bus       (bus),
    .pc        (pc),
    .issue_cnt (issue_cnt),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int                 cyc = 0;
  int                 n_chk = 0;
  int                 n_pass = 0;
  bit                 mon_en = 1'b0;
  exp_t               exp_q[$];
  logic [INSTR_W-1:0] img [64];
  logic [INSTR_W-1:0] issued;

  always @(posedge clk) cyc <= cyc + 1;

  assign issued = {bus.op, bus.op0, bus.op1, bus.op2};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [3:0] o, input logic [9:0] a,
                                             input logic [31:0] b, input logic [9:0] c);
    return {o, a, b, c};
  endfunction

  // Monitor: every non-NOP output must match the head of the scoreboard, on the expected edge.
  always @(negedge clk) begin
    if (mon_en && issued != NopWord) begin
      if (exp_q.size() == 0) begin
        check("spurious_issue", issued, NopWord);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_word", issued, e.w);
        check("issue_edge", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [INSTR_W-1:0] w);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 6'(a);
    bus.ld_data  = w;
    img[a]       = w;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic push(input logic [INSTR_W-1:0] w, input int c);
    exp_t e;
    e.w   = w;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_stop(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("run_end", busy, 0);
  endtask

  initial begin
    int s;
    reset        = 1'b0;
    start        = 1'b0;
    halt_req     = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.op_err   = 1'b0;
`ifdef MCU_SEQUENCER_STEP_EN
    step         = 1'b1;
`endif
    tick();
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pc", pc, 0);
    check("rst_cnt", issue_cnt, 0);
    check("rst_ld_ready", bus.ld_ready, 1);
    check("rst_nop", issued, NopWord);

    // Two issues then END.
    load(0, mk(4'd0, 10'd1, 32'd2, 10'd3));
    load(1, mk(4'd8, 10'd5, 32'h1234, 10'd0));
    load(2, mk(4'd15, 10'd0, 32'd0, 10'd0));
    s = cyc + 1;
    push(img[0], s + 1);
    push(img[1], s + 2);
    go();
    check("run_ld_ready", bus.ld_ready, 0);
    wait_stop(10);
    check("end_done", done, 1);
    check("end_cnt", issue_cnt, 2);
    check("end_pc", pc, 2);
    check("end_nop", issued, NopWord);
    check("end_ld_ready", bus.ld_ready, 1);

    // Restart from DONE with a load to word 0 on the same edge.
    s = cyc + 1;
    img[0] = mk(4'd3, 10'd7, 32'hdead_beef, 10'd9);
    push(img[0], s + 1);
    push(img[1], s + 2);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 6'd0;
    bus.ld_data  = img[0];
    go();
    bus.ld_valid = 1'b0;
    wait_stop(10);
    check("ldstart_done", done, 1);
    check("ldstart_cnt", issue_cnt, 2);

    // Illegal opcode at word 1.
    load(1, mk(4'd11, 10'd1, 32'd1, 10'd1));
    s = cyc + 1;
    push(img[0], s + 1);
    go();
    wait_stop(10);
    check("ill_err", err, 1);
    check("ill_done", done, 0);
    check("ill_pc", pc, 1);
    check("ill_cnt", issue_cnt, 1);
    check("ill_nop", issued, NopWord);

    // Halt on the third RUN edge of a 10-word program.
    for (int i = 0; i < 9; i++) load(i, mk(4'(i), 10'(i + 1), 32'(i * 77 + 5), 10'(3 * i)));
    load(9, mk(4'd15, 10'd0, 32'd0, 10'd0));
    s = cyc + 1;
    push(img[0], s + 1);
    push(img[1], s + 2);
    go();
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_busy", busy, 0);
    check("halt_done", done, 0);
    check("halt_err", err, 0);
    check("halt_cnt", issue_cnt, 2);
    check("halt_pc", pc, 2);
    check("halt_ld_ready", bus.ld_ready, 1);

    // Downstream error on the second RUN edge.
    s = cyc + 1;
    push(img[0], s + 1);
    go();
    tick();
    bus.op_err = 1'b1;
    tick();
    bus.op_err = 1'b0;
    check("operr_err", err, 1);
    check("operr_cnt", issue_cnt, 1);
    check("operr_pc", pc, 1);

    // Full memory: done on the same edge as the 64th issue, pc stays at 63.
    for (int i = 0; i < 64; i++) load(i, mk(4'd0, 10'(i), 32'(i * 3 + 1), ~10'(i)));
    s = cyc + 1;
    for (int i = 0; i < 64; i++) push(img[i], s + 1 + i);
    go();
    repeat (63) tick();
    check("full_busy63", busy, 1);
    check("full_cnt63", issue_cnt, 63);
    tick();
    check("full_done", done, 1);
    check("full_pc", pc, 63);
    check("full_cnt", issue_cnt, 64);

    // Reset mid-run, then rerun the retained program.
    s = cyc + 1;
    for (int i = 0; i < 5; i++) push(img[i], s + 1 + i);
    go();
    repeat (5) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mrst_nop", issued, NopWord);
    check("mrst_busy", busy, 0);
    check("mrst_pc", pc, 0);
    check("mrst_cnt", issue_cnt, 0);
    check("mrst_ld_ready", bus.ld_ready, 1);
    s = cyc + 1;
    for (int i = 0; i < 64; i++) push(img[i], s + 1 + i);
    go();
    wait_stop(80);
    check("rerun_done", done, 1);
    check("rerun_cnt", issue_cnt, 64);

`ifdef MCU_SEQUENCER_STEP_EN
    // Three separated step pulses yield exactly three issues.
    step = 1'b0;
    go();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      push(img[k], cyc + 1);
      tick();
      step = 1'b0;
      tick();
      tick();
    end
    check("step_cnt", issue_cnt, 3);
    check("step_busy", busy, 1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step     = 1'b1;
`endif

    tick();
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
